// File: rtl/round_judge.sv
// round_judge: Rock-Paper-Scissors round referee and match engine.
// Collects one move per player through valid/ready, judges each round,
// keeps scores and a tie count, and ends the match at WIN_TARGET wins.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start; no moves accepted
// COLLECT | accepting one move from each player, in any order
// JUDGE   | single cycle: score the latched moves, pick next state
// DONE    | match decided; scores and winner held until start
module round_judge #(
  parameter int NUM_MOVES  = 3,
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_MOVES-1:0] inA,
  input  logic                 validA,
  output logic                 readyA,
  input  logic [NUM_MOVES-1:0] inB,
  input  logic                 validB,
  output logic                 readyB,
  output logic                 result_valid,
  output logic                 Tie,
  output logic                 winA,
  output logic                 winB,
  output logic                 faultA,
  output logic                 faultB,
  output logic [SCORE_W-1:0]   scoreA,
  output logic [SCORE_W-1:0]   scoreB,
  output logic [SCORE_W-1:0]   tieCount,
  output logic                 match_done,
  output logic                 match_winA,
  output logic                 match_winB
);

  localparam int IDX_W = (NUM_MOVES > 2) ? $clog2(NUM_MOVES) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, JUDGE, DONE} state_t;

  state_t               state;
  logic                 got_a, got_b;
  logic [NUM_MOVES-1:0] move_a, move_b;

  logic                 acc_a, acc_b;
  logic                 legal_a, legal_b;
  logic [IDX_W-1:0]     idx_a, idx_b;
  logic [IDX_W:0]       diff;
  logic                 j_tie, j_wa, j_wb;
  logic [SCORE_W-1:0]   score_a_inc, score_b_inc;
  logic                 final_a, final_b;

  // readyA/readyB are registered copies of ~got in COLLECT, so they gate acceptance directly
  assign acc_a = (state == COLLECT) & validA & readyA;
  assign acc_b = (state == COLLECT) & validB & readyB;

  // decode the latched moves into a round outcome
  always_comb begin
    legal_a = $onehot(move_a);
    legal_b = $onehot(move_b);
    idx_a   = '0;
    idx_b   = '0;
    for (int i = 0; i < NUM_MOVES; i++) begin
      if (move_a[i]) idx_a = IDX_W'(i);
      if (move_b[i]) idx_b = IDX_W'(i);
    end
    // (idx_a - idx_b) mod NUM_MOVES; both indices are below NUM_MOVES
    if (idx_a >= idx_b) diff = {1'b0, idx_a} - {1'b0, idx_b};
    else                diff = {1'b0, idx_a} + (IDX_W+1)'(NUM_MOVES) - {1'b0, idx_b};
    j_tie = 1'b0;
    j_wa  = 1'b0;
    j_wb  = 1'b0;
    if (legal_a && legal_b) begin
      if (idx_a == idx_b) j_tie = 1'b1;
      else if (diff[0])   j_wa  = 1'b1;
      else                j_wb  = 1'b1;
    end else if (legal_a) begin
      j_wa = 1'b1;
    end else if (legal_b) begin
      j_wb = 1'b1;
    end else begin
      j_tie = 1'b1;
    end
    score_a_inc = scoreA + SCORE_W'(1);
    score_b_inc = scoreB + SCORE_W'(1);
    final_a     = j_wa && (score_a_inc == SCORE_W'(WIN_TARGET));
    final_b     = j_wb && (score_b_inc == SCORE_W'(WIN_TARGET));
  end

  // round/match state machine with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      got_a        <= 1'b0;
      got_b        <= 1'b0;
      move_a       <= '0;
      move_b       <= '0;
      readyA       <= 1'b0;
      readyB       <= 1'b0;
      result_valid <= 1'b0;
      Tie          <= 1'b0;
      winA         <= 1'b0;
      winB         <= 1'b0;
      faultA       <= 1'b0;
      faultB       <= 1'b0;
      scoreA       <= '0;
      scoreB       <= '0;
      tieCount     <= '0;
      match_done   <= 1'b0;
      match_winA   <= 1'b0;
      match_winB   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            got_a      <= 1'b0;
            got_b      <= 1'b0;
            readyA     <= 1'b1;
            readyB     <= 1'b1;
            scoreA     <= '0;
            scoreB     <= '0;
            tieCount   <= '0;
            match_done <= 1'b0;
            match_winA <= 1'b0;
            match_winB <= 1'b0;
          end
        end
        COLLECT: begin
          if (acc_a) begin
            move_a <= inA;
            got_a  <= 1'b1;
            readyA <= 1'b0;
          end
          if (acc_b) begin
            move_b <= inB;
            got_b  <= 1'b1;
            readyB <= 1'b0;
          end
          if ((got_a | acc_a) && (got_b | acc_b)) state <= JUDGE;
        end
        JUDGE: begin
          result_valid <= 1'b1;
          Tie          <= j_tie;
          winA         <= j_wa;
          winB         <= j_wb;
          faultA       <= ~legal_a;
          faultB       <= ~legal_b;
          got_a        <= 1'b0;
          got_b        <= 1'b0;
          if (j_wa) scoreA <= score_a_inc;
          if (j_wb) scoreB <= score_b_inc;
          if (j_tie && (tieCount != '1)) tieCount <= tieCount + SCORE_W'(1);
          if (final_a || final_b) begin
            state      <= DONE;
            match_done <= 1'b1;
            match_winA <= final_a;
            match_winB <= final_b;
          end else begin
            state  <= COLLECT;
            readyA <= 1'b1;
            readyB <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// tb_round_judge: directed vectors for round_judge, 3-move and 5-move builds.
module tb_round_judge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // 3-move instance (default parameters)
  logic       start, validA, validB;
  logic [2:0] inA, inB;
  logic       readyA, readyB, result_valid, Tie, winA, winB, faultA, faultB;
  logic [3:0] scoreA, scoreB, tieCount;
  logic       match_done, match_winA, match_winB;

  // 5-move instance, short scores to reach tie saturation
  logic       start5, validA5, validB5;
  logic [4:0] inA5, inB5;
  logic       readyA5, readyB5, result_valid5, Tie5, winA5, winB5, faultA5, faultB5;
  logic [1:0] scoreA5, scoreB5, tieCount5;
  logic       match_done5, match_winA5, match_winB5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  round_judge dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .inA(inA), .validA(validA), .readyA(readyA),
    .inB(inB), .validB(validB), .readyB(readyB),
    .result_valid(result_valid), .Tie(Tie), .winA(winA), .winB(winB),
    .faultA(faultA), .faultB(faultB),
    .scoreA(scoreA), .scoreB(scoreB), .tieCount(tieCount),
    .match_done(match_done), .match_winA(match_winA), .match_winB(match_winB)
  );

  round_judge #(.NUM_MOVES(5), .WIN_TARGET(2), .SCORE_W(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5),
    .inA(inA5), .validA(validA5), .readyA(readyA5),
    .inB(inB5), .validB(validB5), .readyB(readyB5),
    .result_valid(result_valid5), .Tie(Tie5), .winA(winA5), .winB(winB5),
    .faultA(faultA5), .faultB(faultB5),
    .scoreA(scoreA5), .scoreB(scoreB5), .tieCount(tieCount5),
    .match_done(match_done5), .match_winA(match_winA5), .match_winB(match_winB5)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // both moves on one edge, then the judge edge; returns just after result_valid
  task automatic play3(input logic [2:0] a, input logic [2:0] b);
    inA = a; inB = b; validA = 1'b1; validB = 1'b1;
    tick();
    validA = 1'b0; validB = 1'b0;
    tick();
  endtask

  task automatic play5(input logic [4:0] a, input logic [4:0] b);
    inA5 = a; inB5 = b; validA5 = 1'b1; validB5 = 1'b1;
    tick();
    validA5 = 1'b0; validB5 = 1'b0;
    tick();
  endtask

  task automatic start3();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    start = 0; validA = 0; validB = 0; inA = '0; inB = '0;
    start5 = 0; validA5 = 0; validB5 = 0; inA5 = '0; inB5 = '0;

    // reset values
    repeat (2) tick();
    chk_val("rst_result_valid", result_valid, 0);
    chk_val("rst_readyA", readyA, 0);
    chk_val("rst_scoreA", scoreA, 0);
    chk_val("rst_match_done", match_done, 0);
    rst_n = 1'b1;
    tick();
    chk_val("idle_readyA", readyA, 0);

    // rock vs scissors on the same edge
    start3();
    chk_val("start_readyA", readyA, 1);
    chk_val("start_readyB", readyB, 1);
    inA = 3'b001; inB = 3'b100; validA = 1; validB = 1;
    tick();
    validA = 0; validB = 0;
    chk_val("judge_cycle_rv", result_valid, 0);
    tick();
    chk_val("r1_result_valid", result_valid, 1);
    chk_val("r1_winA", winA, 1);
    chk_val("r1_winB", winB, 0);
    chk_val("r1_Tie", Tie, 0);
    chk_val("r1_scoreA", scoreA, 1);
    chk_val("r1_scoreB", scoreB, 0);
    tick();
    chk_val("r1_rv_drop", result_valid, 0);

    // A paper at edge 1, re-valid scissors at edge 2 ignored, B paper at edge 4
    inA = 3'b010; validA = 1;
    tick();
    inA = 3'b100;
    chk_val("r2_readyA_low", readyA, 0);
    tick();
    validA = 0;
    tick();
    inB = 3'b010; validB = 1;
    tick();
    validB = 0;
    tick();
    chk_val("r2_result_valid", result_valid, 1);
    chk_val("r2_Tie", Tie, 1);
    chk_val("r2_winA", winA, 0);
    chk_val("r2_tieCount", tieCount, 1);
    chk_val("r2_scoreA", scoreA, 1);

    // illegal A forfeits
    play3(3'b011, 3'b001);
    chk_val("r3_faultA", faultA, 1);
    chk_val("r3_faultB", faultB, 0);
    chk_val("r3_winB", winB, 1);
    chk_val("r3_scoreB", scoreB, 1);
    // both illegal tie
    play3(3'b000, 3'b000);
    chk_val("r4_Tie", Tie, 1);
    chk_val("r4_faultA", faultA, 1);
    chk_val("r4_faultB", faultB, 1);
    chk_val("r4_tieCount", tieCount, 2);
    // illegal B forfeits
    play3(3'b010, 3'b110);
    chk_val("r5_winA", winA, 1);
    chk_val("r5_faultB", faultB, 1);
    chk_val("r5_scoreA", scoreA, 2);
    chk_val("r5_match_done", match_done, 0);
    // paper vs rock: third A win ends the match
    play3(3'b010, 3'b001);
    chk_val("r6_result_valid", result_valid, 1);
    chk_val("r6_scoreA", scoreA, 3);
    chk_val("r6_match_done", match_done, 1);
    chk_val("r6_match_winA", match_winA, 1);
    chk_val("r6_match_winB", match_winB, 0);
    chk_val("r6_readyA", readyA, 0);
    inA = 3'b001; inB = 3'b100; validA = 1; validB = 1;
    repeat (3) tick();
    validA = 0; validB = 0;
    chk_val("done_rv", result_valid, 0);
    chk_val("done_scoreA", scoreA, 3);
    chk_val("done_hold", match_done, 1);
    start = 1;
    tick();
    start = 0;
    chk_val("restart_scoreA", scoreA, 0);
    chk_val("restart_tieCount", tieCount, 0);
    chk_val("restart_match_done", match_done, 0);
    chk_val("restart_match_winA", match_winA, 0);
    chk_val("restart_winA_hold", winA, 1);
    tick();
    chk_val("restart_readyA", readyA, 1);

    // async reset mid-COLLECT with scoreA = 2 and A latched
    play3(3'b010, 3'b001);
    play3(3'b001, 3'b100);
    chk_val("pre_rst_scoreA", scoreA, 2);
    inA = 3'b001; validA = 1;
    tick();
    validA = 0;
    chk_val("pre_rst_readyA", readyA, 0);
    chk_val("pre_rst_readyB", readyB, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_val("async_scoreA", scoreA, 0);
    chk_val("async_readyB", readyB, 0);
    chk_val("async_winA", winA, 0);
    chk_val("async_result_valid", result_valid, 0);
    tick();
    rst_n = 1'b1;
    inA = 3'b001; inB = 3'b100; validA = 1; validB = 1;
    repeat (3) tick();
    validA = 0; validB = 0;
    chk_val("post_rst_rv", result_valid, 0);
    chk_val("post_rst_readyA", readyA, 0);
    chk_val("post_rst_scoreA", scoreA, 0);
    // rock vs paper after a fresh start: B wins
    start3();
    play3(3'b001, 3'b010);
    chk_val("post_rst_winB", winB, 1);
    chk_val("post_rst_scoreB", scoreB, 1);
    chk_val("post_rst_scoreA2", scoreA, 0);

    // 5-move instance
    start5 = 1;
    tick();
    start5 = 0;
    tick();
    play5(5'b00001, 5'b01000);
    chk_val("m5_r1_winB", winB5, 1);
    chk_val("m5_r1_winA", winA5, 0);
    play5(5'b01000, 5'b00001);
    chk_val("m5_r2_winA", winA5, 1);
    chk_val("m5_r2_scoreA", scoreA5, 1);
    for (int i = 0; i < 4; i++) begin
      play5(5'b00100, 5'b00100);
      chk_val("m5_tie", Tie5, 1);
    end
    chk_val("m5_tie_sat", tieCount5, 3);
    play5(5'b00001, 5'b01000);
    chk_val("m5_scoreB", scoreB5, 2);
    chk_val("m5_match_done", match_done5, 1);
    chk_val("m5_match_winB", match_winB5, 1);
    chk_val("m5_match_winA", match_winA5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
